mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
- Memory/writeback pipeline stage.
- Accepts one retiring instruction per handshake from the execute stage.
- Performs the load/store handshake with data memory, bounded by a timeout.
- Drives the registered writeback triple (de_mw_rd_addr_o, write_en_o, wb_data_o) consumed by the forwarding unit and the register file.
- Stalls the upstream pipeline while a memory access is outstanding.

Parameters:
XLEN, 16, datapath width.
REG_AW, 3, register address width (8 architectural registers, r0 hardwired zero).
MEM_AW, 8, data-memory address width (low MEM_AW bits of the ALU result).
TIMEOUT, 15, max cycles waiting for dmem_ack_i before abort (>=1).

Ports:
clk_i  in  1  clock, rising edge.
rst_ni  in  1  synchronous reset, active-low.
ex_valid_i  in  1  execute stage presents an instruction.
ex_ready_o  out  1  stage can accept (high only in IDLE).
ex_rd_addr_i  in  REG_AW  destination register.
ex_reg_write_i  in  1  instruction writes rd.
ex_mem_read_i  in  1  load.
ex_mem_write_i  in  1  store.
ex_alu_result_i  in  XLEN  ALU result / memory address.
ex_store_data_i  in  XLEN  store data.
flush_i  in  1  kill the instruction presented this cycle.
dmem_req_o  out  1  memory request, held until ack or abort.
dmem_we_o  out  1  1=store, 0=load.
dmem_addr_o  out  MEM_AW  request address.
dmem_wdata_o  out  XLEN  store data.
dmem_ack_i  in  1  memory completion; sampled only while dmem_req_o=1.
dmem_rdata_i  in  XLEN  load data, valid with ack.
de_mw_rd_addr_o  out  REG_AW  writeback destination.
write_en_o  out  1  one-cycle writeback strobe.
wb_data_o  out  XLEN  writeback data.
err_o  out  1  one-cycle pulse on memory timeout.

Behaviour:
- Reset (rst_ni=0 at an edge): state=IDLE, timeout counter=0; all outputs 0 except ex_ready_o=1. Applies mid-MEM_WAIT: request dropped, no writeback, no err_o.
- Accept condition: state==IDLE && ex_valid_i && !flush_i. A flushed or invalid cycle leaves write_en_o=0 next cycle and issues no memory access.
- Non-memory accept in cycle N:
  - In N+1: de_mw_rd_addr_o=ex_rd_addr_i, wb_data_o=ex_alu_result_i, write_en_o=ex_reg_write_i && rd!=0.
  - Latency 1; back-to-back accepts every cycle.
- Memory accept in cycle N (mem_read or mem_write; both set is treated as a load):
  - In N+1: state=MEM_WAIT, dmem_req_o=1, dmem_we_o=store, dmem_addr_o=ex_alu_result_i[MEM_AW-1:0], dmem_wdata_o=ex_store_data_i, write_en_o=0, ex_ready_o=0. Counter is cleared.
  - Request signals are stable until they drop.
- MEM_WAIT, each cycle:
  - dmem_ack_i=1: next cycle state=IDLE, dmem_req_o=0.
    - Load: write_en_o=(rd!=0), wb_data_o=dmem_rdata_i, de_mw_rd_addr_o=rd.
    - Store: write_en_o=0.
    - Ack in the first cycle of req is legal, giving a total load latency of 2.
  - No ack, counter==TIMEOUT-1: next cycle state=IDLE, dmem_req_o=0, err_o=1 for one cycle, write_en_o=0.
  - Otherwise the counter increments.
  - Ack and timeout in the same cycle: ack wins, no err_o.
- flush_i and ex_valid_i are ignored in MEM_WAIT. The in-flight access always completes.
- write_en_o is high for exactly one cycle per retired register-writing instruction. de_mw_rd_addr_o and wb_data_o hold their last values when write_en_o=0.
- write_en_o is never asserted with de_mw_rd_addr_o=0.
- dmem_ack_i while dmem_req_o=0 is ignored.

Test Plan:
- Reset check: rst_ni=0 for 2 cycles in MEM_WAIT -> dmem_req_o=0, write_en_o=0, ex_ready_o=1, err_o=0.
- ALU back-to-back: three accepts (rd=1/2/3, data 0x0011/0x0022/0x0033) in consecutive cycles -> write_en_o high three consecutive cycles, matching rd/data, each 1 cycle after accept.
- Load with ack delay: load rd=5, addr 0x01A4 -> dmem_addr_o=0xA4, ex_ready_o=0. Ack with rdata 0xBEEF after 3 cycles -> next cycle write_en_o=1, rd=5, wb_data_o=0xBEEF, ex_ready_o=1. Also: load rd=0 -> write_en_o stays 0.
- Store zero-wait: store addr 0x10, data 0x1234, ack in first req cycle -> dmem_we_o=1, request lasts 1 cycle, write_en_o never set.
- Timeout: load with no ack -> dmem_req_o high exactly 15 cycles, then err_o pulse, write_en_o=0, IDLE. Also: ack in the 15th cycle -> normal writeback, no err_o.
- Flush: ex_valid_i=1 with flush_i=1 in IDLE -> no request, no writeback. flush_i during MEM_WAIT -> access completes normally.

Source files
------------

// File: rtl/mem_wb_stage.sv
// Memory/writeback stage: retires ALU results, runs the dmem handshake
// with a bounded wait, and drives the registered writeback triple.
module mem_wb_stage #(
  parameter int XLEN    = 16,
  parameter int REG_AW  = 3,
  parameter int MEM_AW  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              ex_valid_i,
  output logic              ex_ready_o,
  input  logic [REG_AW-1:0] ex_rd_addr_i,
  input  logic              ex_reg_write_i,
  input  logic              ex_mem_read_i,
  input  logic              ex_mem_write_i,
  input  logic [XLEN-1:0]   ex_alu_result_i,
  input  logic [XLEN-1:0]   ex_store_data_i,
  input  logic              flush_i,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [MEM_AW-1:0] dmem_addr_o,
  output logic [XLEN-1:0]   dmem_wdata_o,
  input  logic              dmem_ack_i,
  input  logic [XLEN-1:0]   dmem_rdata_i,
  output logic [REG_AW-1:0] de_mw_rd_addr_o,
  output logic              write_en_o,
  output logic [XLEN-1:0]   wb_data_o,
  output logic              err_o
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic {
    IDLE,
    MEM_WAIT
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [REG_AW-1:0] pend_rd_q, pend_rd_d;
  logic [REG_AW-1:0] out_rd_q, out_rd_d;
  logic [XLEN-1:0]   out_data_q, out_data_d;
  logic              wen_q, wen_d;
  logic              err_q, err_d;

  logic accept;
  logic is_mem;
  logic rd_nz;

  assign accept = (state_q == IDLE) && ex_valid_i && !flush_i;
  assign is_mem = ex_mem_read_i || ex_mem_write_i;
  assign rd_nz  = (ex_rd_addr_i != '0);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    pend_rd_d  = pend_rd_q;
    out_rd_d   = out_rd_q;
    out_data_d = out_data_q;
    wen_d      = 1'b0;
    err_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept && is_mem) begin
          state_d   = MEM_WAIT;
          cnt_d     = '0;
          req_d     = 1'b1;
          // load wins when both read and write are flagged
          we_d      = ex_mem_write_i && !ex_mem_read_i;
          addr_d    = ex_alu_result_i[MEM_AW-1:0];
          wdata_d   = ex_store_data_i;
          pend_rd_d = ex_rd_addr_i;
        end else if (accept && ex_reg_write_i && rd_nz) begin
          wen_d      = 1'b1;
          out_rd_d   = ex_rd_addr_i;
          out_data_d = ex_alu_result_i;
        end
      end
      MEM_WAIT: begin
        if (dmem_ack_i) begin
          state_d = IDLE;
          req_d   = 1'b0;
          if (!we_q && pend_rd_q != '0) begin
            wen_d      = 1'b1;
            out_rd_d   = pend_rd_q;
            out_data_d = dmem_rdata_i;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          req_d   = 1'b0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      pend_rd_q  <= '0;
      out_rd_q   <= '0;
      out_data_q <= '0;
      wen_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      pend_rd_q  <= pend_rd_d;
      out_rd_q   <= out_rd_d;
      out_data_q <= out_data_d;
      wen_q      <= wen_d;
      err_q      <= err_d;
    end
  end

  assign ex_ready_o      = (state_q == IDLE);
  assign dmem_req_o      = req_q;
  assign dmem_we_o       = we_q;
  assign dmem_addr_o     = addr_q;
  assign dmem_wdata_o    = wdata_q;
  assign de_mw_rd_addr_o = out_rd_q;
  assign write_en_o      = wen_q;
  assign wb_data_o       = out_data_q;
  assign err_o           = err_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: directed vectors push expected
// writeback/error/request events, monitors pop and compare.
module tb_mem_wb_stage;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        ex_valid_i;
  logic        ex_ready_o;
  logic [2:0]  ex_rd_addr_i;
  logic        ex_reg_write_i;
  logic        ex_mem_read_i;
  logic        ex_mem_write_i;
  logic [15:0] ex_alu_result_i;
  logic [15:0] ex_store_data_i;
  logic        flush_i;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [7:0]  dmem_addr_o;
  logic [15:0] dmem_wdata_o;
  logic        dmem_ack_i;
  logic [15:0] dmem_rdata_i;
  logic [2:0]  de_mw_rd_addr_o;
  logic        write_en_o;
  logic [15:0] wb_data_o;
  logic        err_o;

  mem_wb_stage #(
    .XLEN(16), .REG_AW(3), .MEM_AW(8), .TIMEOUT(15)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o),
    .ex_rd_addr_i(ex_rd_addr_i), .ex_reg_write_i(ex_reg_write_i),
    .ex_mem_read_i(ex_mem_read_i), .ex_mem_write_i(ex_mem_write_i),
    .ex_alu_result_i(ex_alu_result_i),
    .ex_store_data_i(ex_store_data_i), .flush_i(flush_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
    .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i),
    .de_mw_rd_addr_o(de_mw_rd_addr_o), .write_en_o(write_en_o),
    .wb_data_o(wb_data_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int          cyc;
    bit          err;
    logic [2:0]  rd;
    logic [15:0] data;
  } wb_t;

  typedef struct {
    bit          we;
    logic [7:0]  addr;
    logic [15:0] wdata;
    int          len;
  } req_t;

  wb_t  wb_q[$];
  req_t req_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  // writeback / error monitor
  always @(negedge clk_i) begin
    if (write_en_o || err_o) begin
      checks++;
      if (wb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_wb cyc=%0d we=%0b err=%0b rd=%0d data=%h",
                 cyc, write_en_o, err_o, de_mw_rd_addr_o, wb_data_o);
      end else begin
        wb_t e;
        e = wb_q.pop_front();
        if (e.cyc != cyc || e.err != err_o || e.err == write_en_o ||
            (!e.err && (e.rd != de_mw_rd_addr_o || e.data != wb_data_o))) begin
          errors++;
          $display("FAIL wb_event got cyc=%0d we=%0b err=%0b rd=%0d data=%h expected cyc=%0d err=%0b rd=%0d data=%h",
                   cyc, write_en_o, err_o, de_mw_rd_addr_o, wb_data_o,
                   e.cyc, e.err, e.rd, e.data);
        end
      end
    end
    if (write_en_o) begin
      checks++;
      if (de_mw_rd_addr_o == 3'd0) begin
        errors++;
        $display("FAIL wb_rd_zero got rd=0 expected rd!=0");
      end
    end
  end

  // dmem request monitor: contents, stability, duration, ready coupling
  req_t cur;
  int   req_len = 0;
  bit   req_prev = 1'b0;

  always @(negedge clk_i) begin
    checks++;
    if (ex_ready_o != !dmem_req_o) begin
      errors++;
      $display("FAIL ready_vs_req got ready=%0b req=%0b expected ready=%0b",
               ex_ready_o, dmem_req_o, !dmem_req_o);
    end
    if (dmem_req_o && !req_prev) begin
      req_len = 1;
      checks++;
      if (req_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_req got addr=%h we=%0b expected none",
                 dmem_addr_o, dmem_we_o);
        cur = '{we: dmem_we_o, addr: dmem_addr_o,
                wdata: dmem_wdata_o, len: -1};
      end else begin
        cur = req_q.pop_front();
        if (cur.we != dmem_we_o || cur.addr != dmem_addr_o ||
            cur.wdata != dmem_wdata_o) begin
          errors++;
          $display("FAIL req_fields got we=%0b addr=%h wdata=%h expected we=%0b addr=%h wdata=%h",
                   dmem_we_o, dmem_addr_o, dmem_wdata_o,
                   cur.we, cur.addr, cur.wdata);
        end
      end
    end else if (dmem_req_o) begin
      req_len++;
      checks++;
      if (cur.we != dmem_we_o || cur.addr != dmem_addr_o ||
          cur.wdata != dmem_wdata_o) begin
        errors++;
        $display("FAIL req_stable got we=%0b addr=%h wdata=%h expected we=%0b addr=%h wdata=%h",
                 dmem_we_o, dmem_addr_o, dmem_wdata_o,
                 cur.we, cur.addr, cur.wdata);
      end
    end else if (req_prev && cur.len >= 0) begin
      checks++;
      if (req_len != cur.len) begin
        errors++;
        $display("FAIL req_len got %0d cycles expected %0d", req_len, cur.len);
      end
    end
    req_prev = dmem_req_o;
  end

  task automatic idle_inputs();
    ex_valid_i = 0; ex_rd_addr_i = 0; ex_reg_write_i = 0;
    ex_mem_read_i = 0; ex_mem_write_i = 0; ex_alu_result_i = 0;
    ex_store_data_i = 0; flush_i = 0; dmem_ack_i = 0; dmem_rdata_i = 0;
  endtask

  // one non-memory instruction, presented for one cycle
  task automatic alu_op(input logic [2:0] rd, input bit rw,
                        input logic [15:0] data);
    ex_valid_i = 1; ex_rd_addr_i = rd; ex_reg_write_i = rw;
    ex_mem_read_i = 0; ex_mem_write_i = 0; ex_alu_result_i = data;
    if (rw && rd != 0) wb_q.push_back('{cyc + 1, 1'b0, rd, data});
    @(posedge clk_i); #1;
  endtask

  // delay<0: never ack (timeout); else ack after delay cycles of req
  task automatic mem_op(input bit rd_en, input bit wr_en,
                        input logic [2:0] rd, input logic [15:0] addr,
                        input logic [15:0] wdata, input int delay,
                        input logic [15:0] rdata, input bit fl_wait);
    int c;
    logic [15:0] a;
    c = cyc;
    a = addr;
    ex_valid_i = 1; ex_rd_addr_i = rd; ex_reg_write_i = rd_en;
    ex_mem_read_i = rd_en; ex_mem_write_i = wr_en;
    ex_alu_result_i = addr; ex_store_data_i = wdata; flush_i = 0;
    req_q.push_back('{wr_en && !rd_en, a[7:0], wdata,
                      (delay < 0) ? 15 : delay + 1});
    if (delay < 0) wb_q.push_back('{c + 16, 1'b1, 3'd0, 16'h0});
    else if (rd_en && rd != 0) wb_q.push_back('{c + 2 + delay, 1'b0, rd, rdata});
    @(posedge clk_i); #1;
    if (fl_wait) begin
      ex_valid_i = 1; flush_i = 1; ex_rd_addr_i = 3'd1;
      ex_mem_read_i = 0; ex_mem_write_i = 0; ex_alu_result_i = 16'hDEAD;
    end else begin
      ex_valid_i = 0;
    end
    if (delay < 0) begin
      repeat (15) begin @(posedge clk_i); #1; end
    end else begin
      repeat (delay) begin @(posedge clk_i); #1; end
      dmem_ack_i = 1; dmem_rdata_i = rdata;
      @(posedge clk_i); #1;
      dmem_ack_i = 0;
    end
    idle_inputs();
  endtask

  task automatic chk(input string name, input logic [15:0] got,
                     input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  initial begin
    rst_ni = 0;
    idle_inputs();
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_ready", 16'(ex_ready_o), 16'h1);
    chk("rst_req", 16'(dmem_req_o), 16'h0);
    chk("rst_wen", 16'(write_en_o), 16'h0);
    chk("rst_err", 16'(err_o), 16'h0);
    rst_ni = 1;
    @(posedge clk_i); #1;

    // back-to-back ALU retirement, then non-writing cases
    alu_op(3'd1, 1, 16'h0011);
    alu_op(3'd2, 1, 16'h0022);
    alu_op(3'd3, 1, 16'h0033);
    alu_op(3'd4, 0, 16'h0044);
    alu_op(3'd0, 1, 16'h0055);
    idle_inputs();
    @(posedge clk_i); #1;

    mem_op(1, 0, 3'd5, 16'h01A4, 16'h5555, 3, 16'hBEEF, 0);
    mem_op(1, 0, 3'd0, 16'h0020, 16'h0000, 1, 16'h9999, 0);
    mem_op(0, 1, 3'd2, 16'h0010, 16'h1234, 0, 16'hFFFF, 0);
    mem_op(1, 0, 3'd4, 16'h0033, 16'h0000, -1, 16'h0000, 0);
    mem_op(1, 0, 3'd6, 16'h0044, 16'h0001, 14, 16'h0A0A, 0);
    mem_op(1, 0, 3'd7, 16'h0077, 16'h0002, 4, 16'h7777, 1);
    mem_op(1, 1, 3'd3, 16'h02FF, 16'h0003, 2, 16'hC0DE, 0);
    mem_op(1, 0, 3'd1, 16'h0005, 16'h0004, 0, 16'h1111, 0);

    // flushed presentations in IDLE do nothing
    ex_valid_i = 1; flush_i = 1; ex_mem_read_i = 1; ex_rd_addr_i = 3'd2;
    ex_alu_result_i = 16'h0066;
    @(posedge clk_i); #1;
    ex_mem_read_i = 0; ex_reg_write_i = 1;
    @(posedge clk_i); #1;
    idle_inputs();
    // stray ack while idle is ignored
    dmem_ack_i = 1; dmem_rdata_i = 16'hAAAA;
    @(posedge clk_i); #1;
    idle_inputs();
    @(posedge clk_i); #1;

    // reset during MEM_WAIT: request dropped, nothing retired
    ex_valid_i = 1; ex_mem_read_i = 1; ex_reg_write_i = 1;
    ex_rd_addr_i = 3'd5; ex_alu_result_i = 16'h0088;
    ex_store_data_i = 16'h0009;
    req_q.push_back('{1'b0, 8'h88, 16'h0009, 3});
    @(posedge clk_i); #1;
    idle_inputs();
    repeat (2) begin @(posedge clk_i); #1; end
    rst_ni = 0;
    repeat (2) begin @(posedge clk_i); #1; end
    chk("midrst_req", 16'(dmem_req_o), 16'h0);
    chk("midrst_wen", 16'(write_en_o), 16'h0);
    chk("midrst_ready", 16'(ex_ready_o), 16'h1);
    chk("midrst_err", 16'(err_o), 16'h0);
    rst_ni = 1;
    @(posedge clk_i); #1;

    alu_op(3'd6, 1, 16'h0066);
    idle_inputs();
    repeat (4) begin @(posedge clk_i); #1; end

    chk("wb_queue_empty", 16'(wb_q.size()), 16'h0);
    chk("req_queue_empty", 16'(req_q.size()), 16'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout_watchdog got no finish expected finish");
    $fatal(1);
  end

endmodule
